// File: rtl/serial_word_tx_pkg.sv
// Shared types and helpers for the serial word transmitter.
package serial_word_tx_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter width for a 0..value-1 count, never narrower than one bit.
  function automatic int CLOG2_MIN1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/serial_word_tx_bit_timer.sv
// Bit-period timer: counts 0..DIV-1 while enabled, idles at 0 otherwise.
// first_o/last_o are combinational from the count; no backpressure.
module serial_word_tx_bit_timer
  import serial_word_tx_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic first_o,
  output logic last_o
);

  localparam int            CW   = CLOG2_MIN1(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign first_o = en_i && (cnt_q == '0);
  assign last_o  = en_i && (cnt_q == LAST);

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial transmitter: first bit on sdo one cycle after handshake.
// din_ready is low for the whole word; a held din_valid costs one idle (done) cycle.
module serial_word_tx
  import serial_word_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sdo,
  output logic             sframe,
  output logic             bit_strobe,
  output logic             done
);

  localparam int            BW       = CLOG2_MIN1(WIDTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             sdo_q, sdo_d;
  logic             done_q, done_d;
  logic             in_shift;
  logic             bit_first;
  logic             bit_last;
  logic             head_d;

  assign in_shift = (state_q == ST_SHIFT);

  serial_word_tx_bit_timer #(
    .DIV (DIV)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (in_shift),
    .first_o (bit_first),
    .last_o  (bit_last)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (din_valid) begin
          shreg_d   = din;
          bit_cnt_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_last) begin
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            bit_cnt_d = '0;
            shreg_d   = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            shreg_d   = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                  : {1'b0, shreg_q[WIDTH-1:1]};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // sdo is registered, so it is loaded from the word that the shift register is about to hold.
  assign head_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
  assign sdo_d  = (state_d == ST_SHIFT) && head_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      sdo_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      sdo_q     <= sdo_d;
      done_q    <= done_d;
    end
  end

  assign din_ready  = (state_q == ST_IDLE);
  assign sframe     = in_shift;
  assign bit_strobe = bit_first;
  assign sdo        = sdo_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: three instances cover DIV=1/MSB, DIV=3/MSB and DIV=1/LSB.
module tb_serial_word_tx;

  typedef struct {
    logic       vld;
    logic [7:0] din;
    logic       sdo;
    logic       sf;
    logic       bs;
    logic       dn;
    logic       rdy;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       a_vld = 1'b0, b_vld = 1'b0, c_vld = 1'b0;
  logic [7:0] a_din = '0, b_din = '0, c_din = '0;
  logic       a_rdy, a_sdo, a_sf, a_bs, a_done;
  logic       b_rdy, b_sdo, b_sf, b_bs, b_done;
  logic       c_rdy, c_sdo, c_sf, c_bs, c_done;

  int nchk = 0;
  int nerr = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  serial_word_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(a_din), .din_valid(a_vld), .din_ready(a_rdy),
    .sdo(a_sdo), .sframe(a_sf), .bit_strobe(a_bs), .done(a_done));

  serial_word_tx #(.WIDTH(8), .DIV(3), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(b_din), .din_valid(b_vld), .din_ready(b_rdy),
    .sdo(b_sdo), .sframe(b_sf), .bit_strobe(b_bs), .done(b_done));

  serial_word_tx #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .din(c_din), .din_valid(c_vld), .din_ready(c_rdy),
    .sdo(c_sdo), .sframe(c_sf), .bit_strobe(c_bs), .done(c_done));

  task automatic chk(input string name, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_a(input string tag, input logic e_sdo, input logic e_sf,
                       input logic e_bs, input logic e_dn, input logic e_rdy);
    chk({tag, ".sdo"}, a_sdo, e_sdo);
    chk({tag, ".sframe"}, a_sf, e_sf);
    chk({tag, ".bit_strobe"}, a_bs, e_bs);
    chk({tag, ".done"}, a_done, e_dn);
    chk({tag, ".din_ready"}, a_rdy, e_rdy);
  endtask

  function automatic vec_t mk(input logic vld, input logic [7:0] din, input logic sdo,
                              input logic sf, input logic bs, input logic dn, input logic rdy);
    vec_t v;
    v.vld = vld; v.din = din; v.sdo = sdo; v.sf = sf; v.bs = bs; v.dn = dn; v.rdy = rdy;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] pat;
    logic       e_bit;

    // Row i: inputs applied before edge i, expected outputs for the cycle after edge i.
    // Word A5, MSB first, DIV=1.
    tbl.push_back(mk(1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    // Back-to-back F0 then 0F with din_valid held; junk din while busy must be ignored.
    tbl.push_back(mk(1'b1, 8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h99, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));

    // Reset state of all three instances.
    @(negedge clk);
    chk_a("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset.b_ready", b_rdy, 1'b1);
    chk("reset.b_sframe", b_sf, 1'b0);
    chk("reset.c_ready", c_rdy, 1'b1);
    chk("reset.c_sdo", c_sdo, 1'b0);
    rst_n = 1'b1;

    // Idle for 20 cycles with no valid.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_a($sformatf("idle[%0d]", i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      a_vld = tbl[i].vld;
      a_din = tbl[i].din;
      @(posedge clk);
      @(negedge clk);
      chk_a($sformatf("tbl[%0d]", i), tbl[i].sdo, tbl[i].sf, tbl[i].bs, tbl[i].dn, tbl[i].rdy);
    end

    // DIV=3: each bit of A5 held three cycles, done on cycle 25.
    pat = 8'hA5;
    b_vld = 1'b1;
    b_din = 8'hA5;
    @(posedge clk);
    #1 b_vld = 1'b0;
    b_din = 8'h00;
    for (int c = 1; c <= 26; c++) begin
      @(negedge clk);
      if (c <= 24) begin
        e_bit = pat[7 - (c - 1) / 3];
        chk($sformatf("div3[%0d].sdo", c), b_sdo, e_bit);
        chk($sformatf("div3[%0d].sframe", c), b_sf, 1'b1);
        chk($sformatf("div3[%0d].bit_strobe", c), b_bs, ((c - 1) % 3) == 0);
        chk($sformatf("div3[%0d].done", c), b_done, 1'b0);
        chk($sformatf("div3[%0d].din_ready", c), b_rdy, 1'b0);
      end else begin
        chk($sformatf("div3[%0d].sframe", c), b_sf, 1'b0);
        chk($sformatf("div3[%0d].done", c), b_done, c == 25);
        chk($sformatf("div3[%0d].din_ready", c), b_rdy, 1'b1);
        chk($sformatf("div3[%0d].bit_strobe", c), b_bs, 1'b0);
      end
    end

    // LSB first, 01: sdo high only on cycle 1.
    c_vld = 1'b1;
    c_din = 8'h01;
    @(posedge clk);
    #1 c_vld = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c <= 8) begin
        chk($sformatf("lsb[%0d].sdo", c), c_sdo, c == 1);
        chk($sformatf("lsb[%0d].sframe", c), c_sf, 1'b1);
      end else begin
        chk($sformatf("lsb[%0d].done", c), c_done, 1'b1);
        chk($sformatf("lsb[%0d].din_ready", c), c_rdy, 1'b1);
      end
    end

    // Asynchronous reset in the middle of cycle 4 of a word.
    a_vld = 1'b1;
    a_din = 8'hFF;
    @(posedge clk);
    #1 a_vld = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst.pre_sdo", a_sdo, 1'b1);
    chk("midrst.pre_sframe", a_sf, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_a("midrst.during", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1 rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk_a($sformatf("midrst.after[%0d]", c), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/serial_word_tx.md
Name: serial_word_tx

Overview:
- Parallel-to-serial transmitter that produces the single-bit data stream a D-flip-flop sampling stage or serial receiver consumes on its `d` input.
- Accepts a WIDTH-bit word over a valid/ready handshake.
- Shifts the word out on one wire, holding each bit for DIV clock cycles.
- Flags frame boundaries and completion.
- Sits upstream of any `d`/`clk` capture stage in the design and replaces hand-written stimulus sequences.

Parameters:
- WIDTH, 8, bits per word; legal values are 2 or more.
- DIV, 1, clock cycles each bit is held on sdo; legal values are 1 or more.
- MSB_FIRST, 1, 1 = transmit din[WIDTH-1] first; 0 = transmit din[0] first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  word to transmit; sampled only on handshake.
- din_valid  input  1  din holds a word to send.
- din_ready  output  1  block can accept a word this cycle.
- sdo  output  1  serial data out, registered.
- sframe  output  1  high on every cycle a word bit is driven on sdo.
- bit_strobe  output  1  one-cycle pulse on the first cycle of each bit period.
- done  output  1  one-cycle pulse after the last bit period of a word ends.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, sdo=0, sframe=0, bit_strobe=0, done=0, din_ready=1, all counters and the shift register = 0. Release takes effect on the first rising clk edge with rst_n=1.
- States:
  - IDLE: din_ready=1, sdo=0, sframe=0.
  - SHIFT: din_ready=0, sframe=1.
- Handshake: transfer happens on a rising edge where din_valid=1 and din_ready=1. din is captured into the shift register and the state goes IDLE->SHIFT. din_valid while din_ready=0 is ignored; din may change freely.
- Latency: handshake at edge k. First bit appears on sdo and bit_strobe=1 in the cycle after edge k (cycle k+1).
- Bit timing:
  - div_cnt counts 0..DIV-1 within each bit; bit_cnt counts 0..WIDTH-1.
  - When div_cnt reaches DIV-1: div_cnt wraps to 0, the shift register shifts (direction per MSB_FIRST) and bit_cnt increments.
  - bit_strobe=1 exactly when div_cnt==0 in SHIFT.
- End of word:
  - When bit_cnt==WIDTH-1 and div_cnt==DIV-1, the next edge goes SHIFT->IDLE. done=1 for that one following cycle, which is also the first IDLE cycle, with din_ready=1.
  - Total SHIFT duration is exactly WIDTH*DIV cycles.
- Back-to-back words: din_valid held high gives exactly one IDLE cycle (the done cycle) between words. The next word's first bit appears one cycle after done.
- DIV=1: div_cnt is a constant 0 and bit_strobe stays high throughout SHIFT.
- Counter widths: $clog2 of WIDTH and of DIV, with a minimum of 1 bit. No overflow is possible, because the counters wrap only at their terminal values.
- Reset mid-word: the word is abandoned immediately; no done pulse is produced. After release the block is in IDLE with din_ready=1.

Decomposition:
- Shared package/header holds:
  - state encoding constants (ST_IDLE=1'b0, ST_SHIFT=1'b1);
  - a CLOG2_MIN1 width helper function.
- One natural sub-module: bit_timer. It is a DIV-cycle counter with enable, and outputs a first-cycle strobe and a last-cycle terminal tick. The top level owns the FSM, the shift register and bit_cnt.

Test Plan:
1. WIDTH=8, DIV=1, MSB_FIRST=1; din=8'hA5 handshake at edge 0 -> sdo = 1,0,1,0,0,1,0,1 on cycles 1–8; sframe=1 on cycles 1–8; done=1 and din_ready=1 on cycle 9.
2. DIV=3, din=8'hA5 -> each bit held 3 cycles; bit_strobe pulses on cycles 1,4,...,22; done on cycle 25.
3. MSB_FIRST=0, din=8'h01 -> sdo=1 on cycle 1 only, then 0 for cycles 2–8.
4. din_valid held high with 8'hF0 then 8'h0F, DIV=1 -> words on cycles 1–8 and 10–17; cycle 9 has sframe=0 and done=1; din changes while din_ready=0 are ignored.
5. rst_n pulsed low asynchronously mid-clock at cycle 4 of a word -> sdo, sframe and bit_strobe go 0 immediately; no done pulse; din_ready=1 on the first edge after release.
6. din_valid=0 for 20 cycles after reset -> sdo=0, sframe=0, done=0 and din_ready=1 throughout.
